// File: rtl/four_to_one_mux.sv
// -----------------------------------------------------------------------------
// four_to_one_mux
//
// Purpose:
//   4-to-1 datapath selector. Two select bits {a,b} (a is the MSB) steer one
//   of four WIDTH-bit data inputs onto a combinational output X. A registered
//   copy X_q gives downstream synchronous logic a glitch-free value that is
//   defined out of reset.
//
// Ports:
//   clk    in   1      rising-edge clock, used only by the registered path
//   rst_n  in   1      synchronous, active-low reset (clears X_q only)
//   a      in   1      select MSB
//   b      in   1      select LSB
//   A      in   WIDTH  data, chosen when {a,b} = 2'b00
//   B      in   WIDTH  data, chosen when {a,b} = 2'b01
//   C      in   WIDTH  data, chosen when {a,b} = 2'b10
//   D      in   WIDTH  data, chosen when {a,b} = 2'b11
//   X      out  WIDTH  combinational mux result, zero latency
//   X_q    out  WIDTH  X registered on clk
// -----------------------------------------------------------------------------
module four_to_one_mux #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] X_q
);

    logic [1:0]       sel;
    logic [WIDTH-1:0] x_sel;

    assign sel = {a, b};

    // Stage p0: combinational selection.
    // The default arm (reached only for X/Z selects in simulation) falls back
    // to A so every path assigns x_sel and no latch is inferred.
    always_comb begin
        x_sel = A;
        case (sel)
            2'b00:   x_sel = A;
            2'b01:   x_sel = B;
            2'b10:   x_sel = C;
            2'b11:   x_sel = D;
            default: x_sel = A;
        endcase
    end

    assign X = x_sel;

    // Stage p1: registered copy. Reset is sampled only at the clock edge, so
    // pulling rst_n low between edges leaves X_q untouched until the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            X_q <= '0;
        end else begin
            X_q <= x_sel;
        end
    end

endmodule

// File: tb/tb_four_to_one_mux.sv
`timescale 1ns/100ps
module tb_four_to_one_mux;

    logic       clk;
    logic       rst_n;

    // WIDTH=1 instance
    logic       a, b;
    logic [0:0] A, B, C, D;
    logic [0:0] X, X_q;

    // WIDTH=8 instance
    logic       wa, wb;
    logic [7:0] WA, WB, WC, WD;
    logic [7:0] WX, WX_q;

    int checks   = 0;
    int failures = 0;

    four_to_one_mux #(.WIDTH(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .A(A), .B(B), .C(C), .D(D), .X(X), .X_q(X_q)
    );

    four_to_one_mux #(.WIDTH(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .a(wa), .b(wb),
        .A(WA), .B(WB), .C(WC), .D(WD), .X(WX), .X_q(WX_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        a = 1'b1; b = 1'b1; A = 1'b0; B = 1'b0; C = 1'b0; D = 1'b1;
        wa = 1'b1; wb = 1'b1; WA = 8'h00; WB = 8'h00; WC = 8'h00; WD = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (X_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_xq_n actual=%b expected=0", X_q);
        end
        checks++;
        if (WX_q !== 8'h00) begin
            failures++;
            $display("FAIL reset_xq_w actual=%h expected=00", WX_q);
        end
        // X keeps tracking inputs while in reset
        checks++;
        if (X !== 1'b1) begin
            failures++;
            $display("FAIL reset_x_tracks actual=%b expected=1", X);
        end
        checks++;
        if (WX !== 8'hFF) begin
            failures++;
            $display("FAIL reset_wx_tracks actual=%h expected=ff", WX);
        end
    endtask

    // a toggles every 12.5 ns, b 25, A 50, B 100, C 200, D 400; 160 steps = 2000 ns
    task automatic test_sweep();
        int   errs;
        logic exp;
        logic [7:0] cnt;
        errs = 0;
        for (int i = 0; i < 160; i++) begin
            cnt = i[7:0];
            a = cnt[0]; b = cnt[1]; A = cnt[2]; B = cnt[3]; C = cnt[4]; D = cnt[5];
            #1;
            if      (!cnt[0] && !cnt[1]) exp = cnt[2];
            else if (!cnt[0] &&  cnt[1]) exp = cnt[3];
            else if ( cnt[0] && !cnt[1]) exp = cnt[4];
            else                         exp = cnt[5];
            checks++;
            if (X !== exp) begin
                failures++;
                errs++;
                if (errs <= 5)
                    $display("FAIL sweep step=%0d a=%b b=%b A=%b B=%b C=%b D=%b actual=%b expected=%b",
                             i, a, b, A, B, C, D, X, exp);
            end
            #11.5;
        end
    endtask

    task automatic test_isolation();
        logic [2:0] v;
        a = 1'b1; b = 1'b0; C = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            A = v[0]; B = v[1]; D = v[2];
            #1;
            checks++;
            if (X !== 1'b1) begin
                failures++;
                $display("FAIL isolation step=%0d actual=%b expected=1", i, X);
            end
        end
        C = 1'b0;
        #1;
        checks++;
        if (X !== 1'b0) begin
            failures++;
            $display("FAIL isolation_c_toggle actual=%b expected=0", X);
        end
    endtask

    task automatic test_registered();
        rst_n = 1'b1;
        @(negedge clk);
        a = 1'b1; b = 1'b1; D = 1'b0;
        @(negedge clk);
        D = 1'b1;
        #1;
        checks++;
        if (X !== 1'b1) begin
            failures++;
            $display("FAIL reg_x_immediate actual=%b expected=1", X);
        end
        checks++;
        if (X_q !== 1'b0) begin
            failures++;
            $display("FAIL reg_xq_before_edge actual=%b expected=0", X_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (X_q !== 1'b1) begin
            failures++;
            $display("FAIL reg_xq_after_edge actual=%b expected=1", X_q);
        end
    endtask

    task automatic test_sync_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (X_q !== 1'b1) begin
            failures++;
            $display("FAIL sreset_midcycle actual=%b expected=1", X_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (X_q !== 1'b0) begin
            failures++;
            $display("FAIL sreset_edge actual=%b expected=0", X_q);
        end
        checks++;
        if (X !== 1'b1) begin
            failures++;
            $display("FAIL sreset_x_held actual=%b expected=1", X);
        end
        @(posedge clk);
        #1;
        checks++;
        if (X_q !== 1'b0) begin
            failures++;
            $display("FAIL sreset_hold actual=%b expected=0", X_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (X_q !== 1'b0) begin
            failures++;
            $display("FAIL sreset_release_before_edge actual=%b expected=0", X_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (X_q !== 1'b1) begin
            failures++;
            $display("FAIL sreset_release_edge actual=%b expected=1", X_q);
        end
    endtask

    task automatic test_wide();
        logic [7:0] exp_tab [4];
        logic [1:0] s;
        exp_tab[0] = 8'h11; exp_tab[1] = 8'h22; exp_tab[2] = 8'h33; exp_tab[3] = 8'h44;
        WA = 8'h11; WB = 8'h22; WC = 8'h33; WD = 8'h44;
        for (int i = 0; i < 4; i++) begin
            s = i[1:0];
            @(negedge clk);
            wa = s[1]; wb = s[0];
            #1;
            checks++;
            if (WX !== exp_tab[i]) begin
                failures++;
                $display("FAIL wide_x sel=%0d actual=%h expected=%h", i, WX, exp_tab[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (WX_q !== exp_tab[i]) begin
                failures++;
                $display("FAIL wide_xq sel=%0d actual=%h expected=%h", i, WX_q, exp_tab[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_isolation();
        test_registered();
        test_sync_reset();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/four_to_one_mux.md
Name: four_to_one_mux

Overview:
- 4-to-1 selector: two select bits (a, b) choose one of four data inputs (A, B, C, D).
- Drives a combinational output X and a registered copy X_q.
- Used as a basic datapath steering element in lab-level designs.
- X_q gives downstream synchronous logic a glitch-free, reset-defined value.

Parameters:
- WIDTH, 1, bit width of each data input A/B/C/D and of outputs X/X_q.

Ports:
- clk    input   1      rising-edge clock; used only by the registered path.
- rst_n  input   1      synchronous, active-low reset.
- a      input   1      select MSB.
- b      input   1      select LSB.
- A      input   WIDTH  data input, chosen when {a,b}=2'b00.
- B      input   WIDTH  data input, chosen when {a,b}=2'b01.
- C      input   WIDTH  data input, chosen when {a,b}=2'b10.
- D      input   WIDTH  data input, chosen when {a,b}=2'b11.
- X      output  WIDTH  combinational mux result.
- X_q    output  WIDTH  X registered on clk.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Select encoding: sel = {a,b}; a is the MSB.
  - 00 -> A
  - 01 -> B
  - 10 -> C
  - 11 -> D
- Equivalent SOP form (per bit): X = a'b'A | a'bB | ab'C | abD.
- X:
  - Purely combinational, zero latency.
  - Independent of clk and rst_n.
  - Responds to any change on a, b, A, B, C, D within the same delta/timestep.
- Only the selected input may affect X; changes on non-selected inputs leave X unchanged.
- X_q:
  - On each rising clk edge: if rst_n==0, X_q <= 0 (all WIDTH bits); else X_q <= X.
  - Latency from input change to X_q is one clock edge.
  - Reset is sampled only at clk edges; asserting rst_n low between edges does not change X_q until the next edge.
  - Reset mid-operation clears X_q on that edge; X keeps tracking inputs during reset.
- Unknown/X select bits: no specific requirement beyond standard RTL semantics. Implement with a case on {a,b} with a default arm that outputs A, so synthesis infers no latch.
- No internal state other than the X_q register.
- Simultaneous select and data change is resolved combinationally; X reflects the final settled values.

Test Plan:
- Exhaustive combinational sweep, WIDTH=1, no clock needed:
  - Toggle a every 12.5 ns, b every 25, A every 50, B every 100, C every 200, D every 400; run 2000 ns.
  - At every instant, X == selected input per the encoding (e.g. a=0,b=1,B=1 -> X=1; a=1,b=1,D=0 -> X=0).
- Isolation:
  - Hold {a,b}=2'b10 and C=1, toggle A, B, D.
  - X stays 1 throughout; it changes only when C toggles.
- Registered path:
  - rst_n=1; set {a,b}=2'b11, D=1.
  - X=1 immediately; X_q=1 only after the next rising clk edge, not before.
- Synchronous reset:
  - With X=1, drive rst_n=0 mid-cycle.
  - X_q stays 1 until the next rising edge, then becomes 0 and holds 0 while rst_n=0; X stays 1.
  - On release, X_q=1 at the first edge with rst_n=1.
- Wide instance, WIDTH=8:
  - A=8'h11, B=8'h22, C=8'h33, D=8'h44; step {a,b} through 00, 01, 10, 11.
  - X = 11, 22, 33, 44 (hex); X_q follows one edge later.
